// File: rtl/wfg_drive_spi_core.sv
// SPI master output stage: formats 18-bit signed samples into 8..32-bit
// frames and shifts each out as one chip-select-framed DAC write.
module wfg_drive_spi_core #(
    parameter int DIVW = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wfg_drive_spi_tvalid_i,
    output logic            wfg_drive_spi_tready_o,
    input  logic [17:0]     wfg_drive_spi_tdata_i,
    input  logic            ctrl_en_q_i,
    input  logic            ctrl_cpol_q_i,
    input  logic            ctrl_lsbfirst_q_i,
    input  logic [1:0]      ctrl_dff_q_i,
    input  logic [DIVW-1:0] clkcfg_div_q_i,
    output logic            spi_sclk_o,
    output logic            spi_cs_n_o,
    output logic            spi_mosi_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    state_e          state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [5:0]      hcnt_q, hcnt_d;
    logic [31:0]     sh_q, sh_d;
    logic            cpol_q, cpol_d;
    logic            lsb_q, lsb_d;
    logic [1:0]      dff_q, dff_d;
    logic            sclk_q, sclk_d;
    logic            cs_n_q, cs_n_d;
    logic            mosi_q, mosi_d;

    logic            accept;
    logic            tick;
    logic [5:0]      last_half;
    logic [31:0]     word;
    logic [31:0]     load;
    logic [31:0]     sh_next;
    logic            first_bit;
    logic            next_bit;

    assign wfg_drive_spi_tready_o = (state_q == IDLE) && ctrl_en_q_i
                                    && !wb_rst_i;
    assign accept    = wfg_drive_spi_tvalid_i && wfg_drive_spi_tready_o;
    assign busy_o    = (state_q != IDLE);
    assign tick      = (cnt_q == div_q);
    // 2N-1 half-periods index of the last SHIFT tick, N = 8*(dff+1)
    assign last_half = {dff_q, 4'hF};

    always_comb begin
        word = '0;
        unique case (ctrl_dff_q_i)
            2'd0: word = {24'd0, wfg_drive_spi_tdata_i[17:10]};
            2'd1: word = {16'd0, wfg_drive_spi_tdata_i[17:2]};
            2'd2: word = {8'd0, {6{wfg_drive_spi_tdata_i[17]}},
                          wfg_drive_spi_tdata_i};
            2'd3: word = {{14{wfg_drive_spi_tdata_i[17]}},
                          wfg_drive_spi_tdata_i};
        endcase
    end

    // MSB-first frames are left-aligned so the outgoing bit is always sh[31]
    assign load      = ctrl_lsbfirst_q_i ? word
                                         : (word << {~ctrl_dff_q_i, 3'b000});
    assign first_bit = ctrl_lsbfirst_q_i ? load[0] : load[31];
    assign sh_next   = lsb_q ? (sh_q >> 1) : (sh_q << 1);
    assign next_bit  = lsb_q ? sh_next[0] : sh_next[31];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        hcnt_d  = hcnt_q;
        sh_d    = sh_q;
        cpol_d  = cpol_q;
        lsb_d   = lsb_q;
        dff_d   = dff_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + DIVW'(1);
        end

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                hcnt_d = '0;
                cs_n_d = 1'b1;
                sclk_d = ctrl_cpol_q_i;
                if (accept) begin
                    state_d = SETUP;
                    cpol_d  = ctrl_cpol_q_i;
                    lsb_d   = ctrl_lsbfirst_q_i;
                    dff_d   = ctrl_dff_q_i;
                    div_d   = clkcfg_div_q_i;
                    sh_d    = load;
                    mosi_d  = first_bit;
                    cs_n_d  = 1'b0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    hcnt_d = hcnt_q + 6'd1;
                    if (hcnt_q == last_half) begin
                        state_d = HOLD;
                        sclk_d  = cpol_q;
                    end else if (!hcnt_q[0]) begin
                        sclk_d = !cpol_q;
                    end else begin
                        sclk_d = cpol_q;
                        sh_d   = sh_next;
                        mosi_d = next_bit;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            hcnt_q  <= '0;
            sh_q    <= '0;
            cpol_q  <= 1'b0;
            lsb_q   <= 1'b0;
            dff_q   <= 2'd0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            hcnt_q  <= hcnt_d;
            sh_q    <= sh_d;
            cpol_q  <= cpol_d;
            lsb_q   <= lsb_d;
            dff_q   <= dff_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
        end
    end

    assign spi_sclk_o = sclk_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_wfg_drive_spi_core.sv
// Scoreboard bench for wfg_drive_spi_core: frames decoded from the SPI
// pins are compared against a bit-sequence model of each accepted sample.
module tb_wfg_drive_spi_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        tvalid;
    logic        tready;
    logic [17:0] tdata;
    logic        en;
    logic        cpol;
    logic        lsb;
    logic [1:0]  dff;
    logic [7:0]  div;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        busy;

    always #5 clk = ~clk;

    wfg_drive_spi_core #(.DIVW(8)) dut (
        .wb_clk_i               (clk),
        .wb_rst_i               (rst),
        .wfg_drive_spi_tvalid_i (tvalid),
        .wfg_drive_spi_tready_o (tready),
        .wfg_drive_spi_tdata_i  (tdata),
        .ctrl_en_q_i            (en),
        .ctrl_cpol_q_i          (cpol),
        .ctrl_lsbfirst_q_i      (lsb),
        .ctrl_dff_q_i           (dff),
        .clkcfg_div_q_i         (div),
        .spi_sclk_o             (sclk),
        .spi_cs_n_o             (cs_n),
        .spi_mosi_o             (mosi),
        .busy_o                 (busy)
    );

    typedef struct {
        logic [31:0] seq;
        int          n;
        logic        cpol;
        int          t;
    } exp_t;

    exp_t q_exp[$];
    int   q_len[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic rst_hit = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // seq[k] is the k-th bit that must appear on MOSI
    function automatic exp_t model(input logic [17:0] d);
        exp_t        e;
        int          n;
        int          s;
        logic [31:0] w;
        n = 8 * (int'(dff) + 1);
        s = int'(d);
        if (d[17]) s = s - 262144;
        if (n == 8)       w = 32'(d) >> 10;
        else if (n == 16) w = 32'(d) >> 2;
        else if (n == 24) w = 32'(s) & 32'h00FF_FFFF;
        else              w = 32'(s);
        e.seq = '0;
        for (int k = 0; k < n; k++)
            e.seq[k] = lsb ? w[k] : w[n-1-k];
        e.n    = n;
        e.cpol = cpol;
        e.t    = int'(div) + 1;
        return e;
    endfunction

    task automatic send(input logic [17:0] d, input bit keep);
        int   g;
        exp_t e;
        tvalid = 1'b1;
        tdata  = d;
        g = 0;
        while (!tready && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (!tready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: tready got 0 expected 1");
            tvalid = 1'b0;
            return;
        end
        e = model(d);
        q_exp.push_back(e);
        q_len.push_back((2 * e.n + 3) * e.t);
        @(negedge clk);
        if (!keep) tvalid = 1'b0;
    endtask

    task automatic cfg(input int dv, input bit cp, input bit lf,
                       input int df);
        div  = 8'(dv);
        cpol = cp;
        lsb  = lf;
        dff  = 2'(df);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || q_exp.size() != 0 || q_len.size() != 0)
               && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20000) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy got %0d expected 0", busy);
        end
        @(negedge clk);
    endtask

    always @(posedge clk) rst_hit <= rst;

    // Monitor: decodes frames from the pins and pops the scoreboard
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        in_frame = 1'b0;
    logic        idle_lvl = 1'b0;
    logic [31:0] rx_seq = '0;
    int          bits = 0;
    int          cs_cnt = 0;
    int          hi_cnt = 0;
    int          gap_min = 0;
    int          busy_cnt = 0;
    bit          have_prev = 0;
    bit          viol = 0;

    always @(negedge clk) begin
        exp_t e;
        int   el;
        if (rst_hit) begin
            q_exp.delete();
            q_len.delete();
            in_frame  = 1'b0;
            have_prev = 0;
            busy_cnt  = 0;
            hi_cnt    = 0;
            viol      = 0;
        end else begin
            if (tready && busy) viol = 1;
            if (busy) begin
                busy_cnt++;
            end else if (busy_cnt > 0) begin
                if (q_len.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame_len: got %0d cycles expected no frame",
                             busy_cnt);
                end else begin
                    el = q_len.pop_front();
                    chk("frame_len", busy_cnt, el);
                end
                busy_cnt = 0;
            end
            if (prev_cs && !cs_n) begin
                if (have_prev) begin
                    n_cmp++;
                    if (hi_cnt < gap_min) begin
                        n_err++;
                        $display("FAIL cs_gap: got %0d cycles expected >= %0d",
                                 hi_cnt, gap_min);
                    end
                end
                in_frame = 1'b1;
                idle_lvl = sclk;
                rx_seq   = '0;
                bits     = 0;
                cs_cnt   = 0;
            end
            if (in_frame) begin
                if (!cs_n) begin
                    cs_cnt++;
                    if (sclk != prev_sclk && sclk != idle_lvl) begin
                        if (bits < 32) rx_seq[bits] = mosi;
                        bits++;
                    end
                end else begin
                    in_frame = 1'b0;
                    if (q_exp.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL frame_extra: got frame %0h expected none",
                                 rx_seq);
                    end else begin
                        e = q_exp.pop_front();
                        chk("mosi_bits", rx_seq, e.seq);
                        chk("sclk_edges", bits, e.n);
                        chk("sclk_idle", 32'(idle_lvl), 32'(e.cpol));
                        chk("cs_low_len", cs_cnt, (2 * e.n + 2) * e.t);
                        chk("tready_busy", 32'(viol), 0);
                        gap_min   = e.t + 1;
                        have_prev = 1;
                    end
                    viol   = 0;
                    hi_cnt = 0;
                end
            end
            if (cs_n) hi_cnt++;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    initial begin
        rst    = 1'b1;
        tvalid = 1'b0;
        tdata  = '0;
        en     = 1'b1;
        cfg(0, 1, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tready", 32'(tready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_sclk_cpol", 32'(sclk), 1);
        chk("idle_tready", 32'(tready), 1);

        cfg(0, 0, 0, 1);
        send(18'h12345, 0);
        wait_idle();
        cfg(0, 0, 0, 2);
        send(18'h20000, 0);
        wait_idle();
        cfg(0, 0, 0, 3);
        send(18'h20000, 0);
        wait_idle();
        cfg(0, 0, 0, 0);
        send(18'h20000, 0);
        wait_idle();
        cfg(3, 1, 1, 1);
        send(18'h12345, 0);
        wait_idle();

        cfg(1, 0, 0, 1);
        send(18'h0ABCD, 1);
        send(18'h35A5A, 1);
        send(18'h1F0F0, 0);
        wait_idle();

        cfg(2, 0, 0, 3);
        send(18'($urandom), 0);
        repeat (10) @(negedge clk);
        cfg(7, 1, 1, 0);
        wait_idle();

        cfg(1, 0, 0, 2);
        send(18'($urandom), 0);
        repeat (5) @(negedge clk);
        en = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        chk("en_off_tready", 32'(tready), 0);
        chk("en_off_busy", 32'(busy), 0);
        chk("en_off_cs_n", 32'(cs_n), 1);
        en = 1'b1;
        @(negedge clk);

        cfg(2, 1, 0, 3);
        send(18'h3FFFF, 0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n", 32'(cs_n), 1);
        chk("midrst_sclk", 32'(sclk), 0);
        chk("midrst_mosi", 32'(mosi), 0);
        chk("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            bit keep;
            keep = bit'($urandom_range(0, 1));
            cfg(int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            send(18'($urandom), keep);
            if (!keep) wait_idle();
        end
        tvalid = 1'b0;
        wait_idle();

        cfg(255, 0, 1, 0);
        send(18'($urandom), 0);
        wait_idle();

        chk("sb_drain", q_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wfg_drive_spi_core.md
Name: wfg_drive_spi_core

Overview:
- SPI master output stage directly downstream of the sine stimulus generator.
- Accepts 18-bit signed samples over the AXI-Stream handshake and formats each one to a configurable frame width.
- Shifts each frame out MSB- or LSB-first as one chip-select-framed SPI write to an external DAC.
- Configuration comes from the block's Wishbone register file; only the core is specified here.

Parameters:
- DIVW, 8, width of the SCLK half-period divider register.

Ports:
- wb_clk_i  input  1  system clock; the only clock.
- wb_rst_i  input  1  reset; synchronous, active-high.
- wfg_drive_spi_tvalid_i  input  1  AXI-Stream sample valid.
- wfg_drive_spi_tready_o  output  1  AXI-Stream ready.
- wfg_drive_spi_tdata_i  input  18  signed sample.
- ctrl_en_q_i  input  1  enable new frames.
- ctrl_cpol_q_i  input  1  SCLK idle level.
- ctrl_lsbfirst_q_i  input  1  1 = LSB first.
- ctrl_dff_q_i  input  2  frame width: 0 = 8, 1 = 16, 2 = 24, 3 = 32 bits.
- clkcfg_div_q_i  input  DIVW  half-period = div+1 clocks.
- spi_sclk_o  output  1  SPI clock.
- spi_cs_n_o  output  1  chip select, active low.
- spi_mosi_o  output  1  serial data.
- busy_o  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a clock edge), effective on the same edge even mid-frame:
  - FSM goes to IDLE; spi_cs_n_o=1, spi_sclk_o=0, spi_mosi_o=0, busy_o=0, wfg_drive_spi_tready_o=0, divider and bit counters cleared.
  - Any partial frame is abandoned; no completion is emitted.
- Handshake:
  - wfg_drive_spi_tready_o = (state==IDLE) && ctrl_en_q_i && !wb_rst_i; no combinational path from tvalid.
  - A sample is accepted on the edge where tvalid && tready are both high.
  - tready drops the next cycle and stays low until IDLE is re-entered.
  - tdata is ignored at all other times.
- Capture on acceptance: cpol, lsbfirst, dff and div are latched. Register changes mid-frame do not affect the frame in flight.
- Formatting (N = frame width):
  - N=8: tdata[17:10].
  - N=16: tdata[17:2].
  - N=24: tdata sign-extended to 24 bits.
  - N=32: tdata sign-extended to 32 bits.
  - Truncation only, no rounding. The word is loaded into a 32-bit shift register.
- Timing: T = div+1 clock cycles per half-period; a divider counter generates one tick every T cycles.
- FSM states:
  - IDLE: cs_n=1, sclk = live ctrl_cpol_q_i (registered). Accept → SETUP.
  - SETUP (1 half-period): cs_n=0, mosi = first bit, sclk = cpol. Tick → SHIFT.
  - SHIFT (2N half-periods, CPHA=0): odd ticks drive sclk to !cpol (slave samples here); even ticks drive sclk back to cpol and present the next bit on mosi. After the 2N-th tick → HOLD.
  - HOLD (1 half-period): cs_n=0, sclk=cpol, mosi holds the last bit. Tick → GAP.
  - GAP (1 half-period): cs_n=1. Tick → IDLE.
- Frame length: exactly (2N+3)·T cycles from the acceptance edge until tready can rise again. Minimum cs_n high time between frames is T+1 cycles.
- Enable: ctrl_en_q_i falling mid-frame lets the current frame finish normally, then the FSM stays in IDLE with tready=0.
- Divider boundaries: div=0 gives T=1 and SCLK = clk/2. div=all-ones gives T=2^DIVW, with no overflow of the divider counter.
- All outputs are registered (glitch-free SCLK/CS/MOSI).

Test Plan:
- Basic 16-bit frame. Setup: div=0, cpol=0, MSB first, dff=1; send 18'h12345. Required: word 0x48D1 on MOSI, 16 rising SCLK edges with cs_n low, tready high again exactly 35 cycles after acceptance.
- Sign extension. Send 18'h20000 with dff=2 → MOSI carries 0xFE0000 (24 bits). With dff=3 → 0xFFFE0000. With dff=0 → 0x80.
- LSB-first, CPOL=1, div=3. Send 18'h12345 with dff=1, lsbfirst=1. Required: bit order 0x48D1 reversed, SCLK idles high, each half-period 4 cycles, frame length 140 cycles.
- Back-to-back traffic. Hold tvalid high for 3 samples. Required: exactly 3 frames, cs_n high for ≥T+1 cycles between them, no sample dropped or duplicated, tready high only in IDLE.
- Mid-frame events:
  - Change div/dff mid-frame: the frame in flight is unchanged.
  - Deassert ctrl_en_q_i mid-frame: the frame completes, then tready stays 0.
  - Assert wb_rst_i mid-frame: on the next edge cs_n=1, sclk=0, mosi=0, busy=0.
